// File: rtl/divider.sv
// Sequential restoring divider for DIV/DIVU/REM/REMU: one shift-subtract step per cycle,
// with divide-by-zero and signed overflow answered directly from IDLE.
package core_config_pkg;
    localparam int XLEN = 32;
endpackage

module divider
    import core_config_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            is_signed,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic            valid,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    // Handshake: start is taken only in IDLE (busy low); valid is a one-cycle pulse in which
    // quotient/remainder are final; there is no back-pressure, and start is accepted in the
    // same cycle as valid because the block is already back in IDLE then.

    localparam int CW = $clog2(XLEN);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] CALC = 1'b1;
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic [0:0]      state;
    logic [CW-1:0]   count;
    logic [XLEN:0]   prem;
    logic [XLEN-1:0] dreg;
    logic [XLEN-1:0] dvsr;
    logic            neg_q;
    logic            neg_r;

    logic            dividend_neg;
    logic            divisor_neg;
    logic [XLEN-1:0] dividend_abs;
    logic [XLEN-1:0] divisor_abs;
    logic            div_zero;
    logic            overflow;
    logic [XLEN+1:0] trial;
    logic            q_bit;
    logic [XLEN:0]   next_prem;
    logic [XLEN-1:0] next_dreg;

    always_comb begin
        dividend_neg = is_signed & dividend[XLEN-1];
        divisor_neg  = is_signed & divisor[XLEN-1];
        dividend_abs = dividend_neg ? (-dividend) : dividend;
        divisor_abs  = divisor_neg ? (-divisor) : divisor;
        div_zero     = (divisor == '0);
        overflow     = is_signed && (dividend == MIN_NEG) && (divisor == '1);

        // One extra bit above the shifted remainder so the borrow lands in trial[XLEN+1].
        trial     = {prem, dreg[XLEN-1]} - {2'b00, dvsr};
        q_bit     = ~trial[XLEN+1];
        next_prem = q_bit ? trial[XLEN:0] : {prem[XLEN-1:0], dreg[XLEN-1]};
        next_dreg = {dreg[XLEN-2:0], q_bit};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            count     <= '0;
            prem      <= '0;
            dreg      <= '0;
            dvsr      <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            busy      <= 1'b0;
            valid     <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (div_zero) begin
                            quotient  <= '1;
                            remainder <= dividend;
                            valid     <= 1'b1;
                        end else if (overflow) begin
                            quotient  <= MIN_NEG;
                            remainder <= '0;
                            valid     <= 1'b1;
                        end else begin
                            dreg  <= dividend_abs;
                            dvsr  <= divisor_abs;
                            neg_q <= dividend_neg ^ divisor_neg;
                            neg_r <= dividend_neg;
                            prem  <= '0;
                            count <= '0;
                            busy  <= 1'b1;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    prem  <= next_prem;
                    dreg  <= next_dreg;
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        // The dividend register now holds the quotient magnitude.
                        quotient  <= neg_q ? (-next_dreg) : next_dreg;
                        remainder <= neg_r ? (-next_prem[XLEN-1:0]) : next_prem[XLEN-1:0];
                        valid     <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
